branch_predictor_gshare: RTL and testbench

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

---
 rtl/branch_predictor_gshare.sv | 177 +++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// Gshare-style conditional branch predictor with an in-flight queue of unresolved predictions.
// Define BP_GSHARE_EN to hash the pattern-table index with global history; otherwise it is PC-indexed only.
module branch_predictor_gshare #(
    parameter int TABLE_W = 6,
    parameter int QUEUE_W = 3,
    parameter int CNT_W   = 2,
    parameter int HIST_W  = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 branch,
    input  logic [31:0]          imm,
    input  logic                 inst_length,
    input  logic                 foq_full,
    input  logic [31:0]          pc_in,
    input  logic                 cdb_active,
    input  logic [31:0]          cdb_addr,
    input  logic [31:0]          cdb_val,
    output logic                 need_branch,
    output logic [31:0]          branch_addr,
    output logic                 predict_fail,
    output logic [31:0]          fail_addr,
    output logic                 bp_full,
    output logic [QUEUE_W:0]     inflight
);

    localparam int ENTRIES = 1 << TABLE_W;
    localparam int DEPTH   = 1 << QUEUE_W;
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]   CNT_INIT = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [QUEUE_W:0]   DEPTH_C  = (QUEUE_W+1)'(DEPTH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic [CNT_W-1:0]   cnt_q   [ENTRIES];
    logic [CNT_W-1:0]   cnt_d   [ENTRIES];
    logic [31:0]        q_pc_q  [DEPTH];
    logic [31:0]        q_pc_d  [DEPTH];
    logic [31:0]        q_alt_q [DEPTH];
    logic [31:0]        q_alt_d [DEPTH];
    logic               q_pred_q[DEPTH];
    logic               q_pred_d[DEPTH];
    logic [TABLE_W-1:0] q_idx_q [DEPTH];
    logic [TABLE_W-1:0] q_idx_d [DEPTH];
    logic [QUEUE_W-1:0] front_q, front_d;
    logic [QUEUE_W-1:0] rear_q, rear_d;
    logic [QUEUE_W:0]   count_q, count_d;

    logic [TABLE_W-1:0] index;
    logic               accept, pred, resolve, mispredict, full;
    logic [31:0]        seq_addr, tgt_addr;
    logic [31:0]        head_pc, head_alt;
    logic               head_pred;
    logic [TABLE_W-1:0] head_idx;

`ifdef BP_GSHARE_EN
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [HIST_W-1:0]  q_ghr_q [DEPTH];
    logic [HIST_W-1:0]  q_ghr_d [DEPTH];
    assign index = pc_in[TABLE_W:1] ^ TABLE_W'(ghr_q);
`else
    wire [HIST_W-1:0]   ghr_unused = '0;
    assign index = pc_in[TABLE_W:1];
`endif

    wire unused_bits = &{1'b0, pc_in[31:TABLE_W+1], pc_in[0], cdb_val[31:1]};

    assign full      = (count_q == DEPTH_C);
    assign accept    = branch && rdy_in && !foq_full && !full;
    assign pred      = cnt_q[index][CNT_W-1];
    assign seq_addr  = pc_in + (inst_length ? 32'd4 : 32'd2);
    assign tgt_addr  = pc_in + imm;

    assign head_pc   = q_pc_q[front_q];
    assign head_alt  = q_alt_q[front_q];
    assign head_pred = q_pred_q[front_q];
    assign head_idx  = q_idx_q[front_q];

    assign resolve    = rdy_in && cdb_active && (count_q != '0) && (cdb_addr == head_pc);
    assign mispredict = resolve && (head_pred != cdb_val[0]);

    assign need_branch  = accept && pred;
    assign branch_addr  = accept ? (pred ? tgt_addr : seq_addr) : 32'd0;
    assign predict_fail = mispredict;
    assign fail_addr    = mispredict ? head_alt : 32'd0;
    assign bp_full      = full;
    assign inflight     = count_q;

    always_comb begin
        cnt_d    = cnt_q;
        q_pc_d   = q_pc_q;
        q_alt_d  = q_alt_q;
        q_pred_d = q_pred_q;
        q_idx_d  = q_idx_q;
        front_d  = front_q;
        rear_d   = rear_q;
        count_d  = count_q;
`ifdef BP_GSHARE_EN
        ghr_d    = ghr_q;
        q_ghr_d  = q_ghr_q;
`endif
        if (resolve) begin
            cnt_d[head_idx] = cdb_val[0] ? sat_inc(cnt_q[head_idx]) : sat_dec(cnt_q[head_idx]);
        end
        // A mispredict discards every younger prediction, including one accepted this cycle.
        if (mispredict) begin
            front_d = '0;
            rear_d  = '0;
            count_d = '0;
`ifdef BP_GSHARE_EN
            ghr_d   = (q_ghr_q[front_q] << 1) | HIST_W'(cdb_val[0]);
`endif
        end else begin
            if (accept) begin
                q_pc_d[rear_q]   = pc_in;
                q_alt_d[rear_q]  = pred ? seq_addr : tgt_addr;
                q_pred_d[rear_q] = pred;
                q_idx_d[rear_q]  = index;
                rear_d           = rear_q + QUEUE_W'(1);
`ifdef BP_GSHARE_EN
                q_ghr_d[rear_q]  = ghr_q;
                ghr_d            = (ghr_q << 1) | HIST_W'(pred);
`endif
            end
            if (resolve) begin
                front_d = front_q + QUEUE_W'(1);
            end
            case ({accept, resolve})
                2'b10:   count_d = count_q + (QUEUE_W+1)'(1);
                2'b01:   count_d = count_q - (QUEUE_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_INIT;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc_q[i]   <= '0;
                q_alt_q[i]  <= '0;
                q_pred_q[i] <= 1'b0;
                q_idx_q[i]  <= '0;
`ifdef BP_GSHARE_EN
                q_ghr_q[i]  <= '0;
`endif
            end
            front_q <= '0;
            rear_q  <= '0;
            count_q <= '0;
`ifdef BP_GSHARE_EN
            ghr_q   <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            q_pc_q   <= q_pc_d;
            q_alt_q  <= q_alt_d;
            q_pred_q <= q_pred_d;
            q_idx_q  <= q_idx_d;
            front_q  <= front_d;
            rear_q   <= rear_d;
            count_q  <= count_d;
`ifdef BP_GSHARE_EN
            q_ghr_q  <= q_ghr_d;
            ghr_q    <= ghr_d;
`endif
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Scoreboard bench for branch_predictor_gshare: directed vectors queue expected outputs, a negedge monitor checks them.
module tb_branch_predictor_gshare;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] imm = '0;
    logic        inst_length = 1'b1;
    logic        foq_full = 1'b0;
    logic [31:0] pc_in = '0;
    logic        cdb_active = 1'b0;
    logic [31:0] cdb_addr = '0;
    logic [31:0] cdb_val = '0;
    logic        need_branch;
    logic [31:0] branch_addr;
    logic        predict_fail;
    logic [31:0] fail_addr;
    logic        bp_full;
    logic [3:0]  inflight;

    branch_predictor_gshare dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .branch(branch), .imm(imm),
        .inst_length(inst_length), .foq_full(foq_full), .pc_in(pc_in),
        .cdb_active(cdb_active), .cdb_addr(cdb_addr), .cdb_val(cdb_val),
        .need_branch(need_branch), .branch_addr(branch_addr), .predict_fail(predict_fail),
        .fail_addr(fail_addr), .bp_full(bp_full), .inflight(inflight)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string       name;
        logic        nb;
        logic [31:0] ba;
        logic        pf;
        logic [31:0] fa;
        logic [3:0]  inf;
        logic        full;
        logic        cg;
        logic [3:0]  ghr;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, fld, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue the outputs expected during that cycle.
    task automatic cyc(input string nm, input logic br, input logic [31:0] pc, input logic [31:0] im,
                       input logic len, input logic foq, input logic cact, input logic [31:0] caddr,
                       input logic cval, input logic rdy, input logic enb, input logic [31:0] eba,
                       input logic epf, input logic [31:0] efa, input logic [3:0] einf,
                       input logic efull, input logic cg = 1'b0, input logic [3:0] eg = 4'd0);
        exp_t e;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0; rdy_in = rdy; branch = br; pc_in = pc; imm = im; inst_length = len;
        foq_full = foq; cdb_active = cact; cdb_addr = caddr; cdb_val = {31'd0, cval};
        e.name = nm; e.nb = enb; e.ba = eba; e.pf = epf; e.fa = efa; e.inf = einf;
        e.full = efull; e.cg = cg; e.ghr = eg;
        sb.push_back(e);
    endtask

    task automatic do_rst(input int n);
        @(posedge clk_in);
        #1;
        rst_in = 1'b1; rdy_in = 1'b0; branch = 1'b1; pc_in = 32'h10C; cdb_active = 1'b1;
        cdb_addr = 32'h100;
        repeat (n - 1) @(posedge clk_in);
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.name, "need_branch", 32'(need_branch), 32'(e.nb));
            chk(e.name, "branch_addr", branch_addr, e.ba);
            chk(e.name, "predict_fail", 32'(predict_fail), 32'(e.pf));
            chk(e.name, "fail_addr", fail_addr, e.fa);
            chk(e.name, "inflight", 32'(inflight), 32'(e.inf));
            chk(e.name, "bp_full", 32'(bp_full), 32'(e.full));
`ifdef BP_GSHARE_EN
            if (e.cg) chk(e.name, "ghr", 32'(dut.ghr_q), 32'(e.ghr));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc, ba;
        logic        len;
        do_rst(2);
`ifndef BP_GSHARE_EN
        cyc("rst_idle",     1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 1'b0);
        cyc("push_100",     1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("res_100_t_mp", 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h120, 4'd1, 1'b0);
        cyc("push_100_b",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("res_100_t_ok", 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd1, 1'b0);
        cyc("push_100_c",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("res_100_n_mp", 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 4'd1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            pc  = 32'h100 + 32'(4 * k);
            len = (k != 1);
            ba  = pc + (len ? 32'd4 : 32'd2);
            cyc($sformatf("fill_%0d", k), 1'b1, pc, 32'h40, len, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                1'b0, ba, 1'b0, 32'h0, 4'(k - 1), 1'b0);
        end
        cyc("ninth_blocked",1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd8, 1'b1);
        cyc("pop_full_blk", 1'b1, 32'h200, 32'h20, 1'b1, 1'b0, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd8, 1'b1);
        cyc("push_pop",     1'b1, 32'h300, 32'h20, 1'b1, 1'b0, 1'b1, 32'h108, 1'b0, 1'b1, 1'b1, 32'h320, 1'b0, 32'h0,   4'd7, 1'b0);
        cyc("res_10c_mp",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h10C, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h14C, 4'd7, 1'b0);
        cyc("push_100_d",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("cdb_other_pc", 1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd1, 1'b0);
        cyc("rdy_low",      1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   4'd1, 1'b0);
        cyc("foq_full",     1'b1, 32'h104, 32'h40, 1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd1, 1'b0);
        cyc("res_100_n_mp2",1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 4'd1, 1'b0);
        cyc("push3_a",      1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("push3_b",      1'b1, 32'h108, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h10C, 1'b0, 32'h0,   4'd1, 1'b0);
        cyc("push3_c",      1'b1, 32'h110, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h114, 1'b0, 32'h0,   4'd2, 1'b0);
        cyc("mp_3_push",    1'b1, 32'h104, 32'h40, 1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h108, 1'b1, 32'h120, 4'd3, 1'b0);
        cyc("flushed",      1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 1'b0);
        cyc("push_100_e",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("same_pc_mp",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h120, 1'b1, 32'h104, 4'd1, 1'b0);
        cyc("push_100_f",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("same_pc_ok",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   4'd1, 1'b0);
        cyc("after_same",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd1, 1'b0);
        do_rst(1);
        cyc("post_rst",     1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 1'b0);
        cyc("push_10c",     1'b1, 32'h10C, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h110, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("after_10c",    1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd1, 1'b0);
`else
        cyc("g_push_100",   1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 4'd0);
        cyc("g_mp_taken",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h120, 4'd1, 1'b0, 1'b1, 4'd0);
        cyc("g_ghr_0001",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 4'd1);
        for (int k = 0; k < 4; k++)
            cyc($sformatf("g_nt_%0d", k), 1'b1, 32'h140, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1,
                1'b0, 32'h144, 1'b0, 32'h0, 4'(k), 1'b0);
        for (int k = 0; k < 4; k++)
            cyc($sformatf("g_res_%0d", k), 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h140, 1'b0, 1'b1,
                1'b0, 32'h0, 1'b0, 32'h0, 4'(4 - k), 1'b0);
        cyc("g_ghr_0000",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 4'd0);
        cyc("g_pred_t1",    1'b1, 32'h100, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h120, 1'b0, 32'h0,   4'd0, 1'b0);
        cyc("g_pred_t2",    1'b1, 32'h102, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h122, 1'b0, 32'h0,   4'd1, 1'b0);
        cyc("g_pred_n3",    1'b1, 32'h140, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h144, 1'b0, 32'h0,   4'd2, 1'b0);
        cyc("g_ghr_0110",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd3, 1'b0, 1'b1, 4'd6);
        cyc("g_mp_first",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 4'd3, 1'b0);
        cyc("g_restored",   1'b0, 32'h0,   32'h0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   4'd0, 1'b0, 1'b1, 4'd0);
`endif
        repeat (2) @(posedge clk_in);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
